dac_elem_sel_ctrl: RTL

Sequential element-selection controller for the segmented DAC unit array. Each sample it receives a thermometer count k and one W-bit priority per unit element. It then enables the k elements with the largest priority, one max-search pick per clock. Used ahead of the unit-element drivers for mismatch-shaped element rotation.

---
 rtl/dac_elem_sel_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dac_elem_sel_ctrl.sv
// rtl/dac_elem_sel_ctrl.sv - sequential max-priority unit-element selection controller
//
// Takes one sample request (count k, one priority per unit element) and then
// enables the k elements with the largest priority, one pick per clock.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   sample request valid
//   in_ready   controller can accept a request (IDLE)
//   in_cnt     number of elements to enable, saturated to N
//   in_pri     packed priorities, element i at [i*W +: W], unsigned
//   out_valid  selection result valid (DONE)
//   out_ready  downstream accepts result
//   out_sel    per-element enable vector, bit i = element i
//   out_cnt    number of bits set in out_sel
//   busy       state is not IDLE
module dac_elem_sel_ctrl #(
  parameter int N  = 6,
  parameter int W  = 6,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_cnt,
  input  logic [N*W-1:0]  in_pri,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_sel,
  output logic [CW-1:0]   out_cnt,
  output logic            busy
);

  // The comparator tree below is hand-built for exactly six elements.
  localparam int IW = 3;

  typedef enum logic [1:0] {IDLE, PICK, DONE} state_t;

  state_t           state_q, state_d;
  logic [N*W-1:0]   pri_q;
  logic [N-1:0]     mask_q;
  logic [N-1:0]     sel_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    remain_q;
  logic [CW-1:0]    k_sat;

  // Search keys: the top bit marks an unmasked element, so a masked element
  // (key 0) always loses, even against an unmasked element of priority 0.
  logic [W:0]       key [N];

  logic [W+IW:0]    n54, n32, n10, n3210, nfin;
  logic [IW-1:0]    win_idx;
  logic [N-1:0]     win_oh;

  // Node result is {key, index}. Argument a is the higher-index side, so a
  // tie keeps b and the lower index wins.
  function automatic logic [W+IW:0] cmp2(input logic [W+IW:0] a, input logic [W+IW:0] b);
    return (a[W+IW:IW] > b[W+IW:IW]) ? a : b;
  endfunction

  always_comb begin
    k_sat = (in_cnt > CW'(N)) ? CW'(N) : in_cnt;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      key[i] = mask_q[i] ? '0 : {1'b1, pri_q[i*W +: W]};
    end
  end

  always_comb begin
    n54     = cmp2({key[5], IW'(5)}, {key[4], IW'(4)});
    n32     = cmp2({key[3], IW'(3)}, {key[2], IW'(2)});
    n10     = cmp2({key[1], IW'(1)}, {key[0], IW'(0)});
    n3210   = cmp2(n32, n10);
    nfin    = cmp2(n54, n3210);
    win_idx = nfin[IW-1:0];
    win_oh  = N'(1) << win_idx;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (k_sat != '0) ? PICK : DONE;
      PICK: if (remain_q == CW'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pri_q    <= '0;
      mask_q   <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pri_q    <= in_pri;
            mask_q   <= '0;
            sel_q    <= '0;
            remain_q <= k_sat;
            cnt_q    <= k_sat;
          end
        end
        PICK: begin
          mask_q   <= mask_q | win_oh;
          sel_q    <= sel_q | win_oh;
          remain_q <= remain_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sel   = sel_q;
  assign out_cnt   = cnt_q;

endmodule
